// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation controller.
// The RSA core can import the same state type, default width and constant.
package modexp_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [DEFAULT_WIDTH-1:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        SQ_REQ  = 3'd2,
        MUL_REQ = 3'd3,
        FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/modexp_ctrl_exp_bit_scanner.sv
// Exponent bit walker: holds the current bit index (MSB first) and reports
// whether the selected exponent bit is set and whether it is bit 0.
module exp_bit_scanner #(
    parameter int WIDTH = 16,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_exp,
    output logic             o_bit,
    output logic             o_last
);

    logic [IW-1:0] r_idx;

    // Index register: load to the MSB on a new operation, step down on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= IW'(WIDTH - 1);
        end else if (i_dec) begin
            r_idx <= r_idx - 1'b1;
        end
    end

    assign o_bit  = i_exp[r_idx];
    assign o_last = (r_idx == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller for M^E mod N.
// All modular products are delegated to an external multiplier.
//
// Multiplier handshake: mul_req rises with mul_a/mul_b/mul_n already valid and
// all four stay constant up to and including the cycle mul_ack is seen high.
// mul_r is captured in the mul_ack cycle, mul_req drops in the next cycle, and
// mul_ack is ignored whenever mul_req is low. Only one request is ever open.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             mul_req,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    input  logic             mul_ack,
    input  logic [WIDTH-1:0] mul_r,
    output logic [2:0]       o_dbg_state
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_mul_req;

    logic w_illegal;
    logic w_ack;
    logic w_load;
    logic w_dec;
    logic w_bit;
    logic w_last;

    assign w_illegal = (n == '0) || (msg >= n);
    assign w_ack     = r_mul_req & mul_ack;

    exp_bit_scanner #(.WIDTH(WIDTH)) u_scanner (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_exp  (r_e),
        .o_bit  (w_bit),
        .o_last (w_last)
    );

    // Scanner control: load on an accepted legal start, step once a bit is consumed.
    always_comb begin
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE:    w_load = start & ~w_illegal;
            SCAN:    w_dec  = ~w_last;
            SQ_REQ:  w_dec  = w_ack & ~w_bit & ~w_last;
            MUL_REQ: w_dec  = w_ack & ~w_last;
            default: ;
        endcase
    end

    // Main sequencer: operand capture, bit scan, square/multiply requests, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_e       <= '0;
            r_n       <= '0;
            r_r       <= '0;
            r_result  <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mul_req <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_illegal) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_m     <= msg;
                            r_e     <= exp;
                            r_n     <= n;
                            r_busy  <= 1'b1;
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_bit) begin
                        // Leading one: R starts as M, no multiply needed.
                        r_r     <= r_m;
                        r_state <= w_last ? FINISH : SQ_REQ;
                    end else if (w_last) begin
                        // E == 0: M^0 is 1, except that 1 mod 1 is 0.
                        r_r     <= (r_n == ONE_W) ? '0 : ONE_W;
                        r_state <= FINISH;
                    end
                end
                SQ_REQ: begin
                    if (!r_mul_req) begin
                        r_mul_req <= 1'b1;
                        r_mul_a   <= r_r;
                        r_mul_b   <= r_r;
                    end else if (mul_ack) begin
                        r_r       <= mul_r;
                        r_mul_req <= 1'b0;
                        if (w_bit) begin
                            r_state <= MUL_REQ;
                        end else if (w_last) begin
                            r_state <= FINISH;
                        end
                    end
                end
                MUL_REQ: begin
                    if (!r_mul_req) begin
                        r_mul_req <= 1'b1;
                        r_mul_a   <= r_r;
                        r_mul_b   <= r_m;
                    end else if (mul_ack) begin
                        r_r       <= mul_r;
                        r_mul_req <= 1'b0;
                        r_state   <= w_last ? FINISH : SQ_REQ;
                    end
                end
                FINISH: begin
                    r_result <= r_r;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;
    assign mul_req     = r_mul_req;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_n       = r_n;
    assign o_dbg_state = r_state;

endmodule
